serial_add_seq: RTL and testbench

- Sequencer that drives one bit-serial addition over the CIM array, LSB to MSB, one bit plane per cycle.
- Issues dual-row reads of operand bit planes A and B, and passes the resulting and/xor planes through to the serial adder.
- Drives the adder's carry load/update controls and writes each returned sum plane back to a destination row.
- Sits between the array row decoder/sense path and the serial adder datapath; it is the controlling end of the adder's interface.

---
 rtl/serial_add_seq.sv | 158 +++++++++++++++
 tb/tb_serial_add_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
`default_nettype none
//==============================================================================
// Module      : serial_add_seq
// Description : Bit-serial add sequencer over the CIM array (LSB first, one
//               bit plane per cycle). Optional final-carry write-back is built
//               when SERIAL_ADD_CARRY_WB_EN is defined.
// Revision    : 1.0
//==============================================================================
module serial_add_seq #(
    parameter int LANES    = 32,
    parameter int MAX_BITS = 32,
    parameter int ADDR_W   = 8
) (
    input  logic              sys_clk_in,
    input  logic              sys_reset_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [ADDR_W-1:0] a_base_in,
    input  logic [ADDR_W-1:0] b_base_in,
    input  logic [ADDR_W-1:0] dst_base_in,
    input  logic [5:0]        nbits_in,
    input  logic [LANES-1:0]  carry_init_in,
    output logic              ready_out,
    output logic              done_out,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_a_out,
    output logic [ADDR_W-1:0] rd_addr_b_out,
    input  logic [LANES-1:0]  and_in,
    input  logic [LANES-1:0]  xor_in,
    output logic [LANES-1:0]  and_out,
    output logic [LANES-1:0]  xor_out,
    output logic              load_carry_out,
    output logic              update_carry_out,
    output logic [LANES-1:0]  carry_out,
    input  logic [LANES-1:0]  sum_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [LANES-1:0]  wr_data_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_CARRY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef SERIAL_ADD_CARRY_WB_EN
    localparam bit c_carry_wb = 1'b1;
`else
    localparam bit c_carry_wb = 1'b0;
`endif
    localparam logic [5:0] c_max_bits = 6'(MAX_BITS);

    state_t              state_q, state_d;
    logic [5:0]          k_q, k_d;
    logic [5:0]          n_q, n_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d;
    logic [ADDR_W-1:0]   b_base_q, b_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [LANES-1:0]    carry_init_q, carry_init_d;

    logic                w_accept;
    logic                w_abort;
    logic                w_last;
    logic [5:0]          w_nbits_clamped;
    logic [5:0]          w_rd_idx;
    logic [5:0]          w_wr_idx;

    assign w_accept        = start_in && (state_q == S_IDLE);
    assign w_abort         = abort_in && (state_q != S_IDLE);
    assign w_last          = (k_q == (n_q - 6'd1));
    assign w_nbits_clamped = (nbits_in > c_max_bits) ? c_max_bits : nbits_in;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        a_base_d     = a_base_q;
        b_base_d     = b_base_q;
        dst_base_d   = dst_base_q;
        carry_init_d = carry_init_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    n_d          = w_nbits_clamped;
                    a_base_d     = a_base_in;
                    b_base_d     = b_base_in;
                    dst_base_d   = dst_base_in;
                    carry_init_d = carry_init_in;
                    state_d      = (w_nbits_clamped == 6'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                k_d     = 6'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (w_last) begin
                    state_d = c_carry_wb ? S_CARRY : S_DONE;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            S_CARRY: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition out of a busy state.
        if (w_abort) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk_in or posedge sys_reset_in) begin
        if (sys_reset_in) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            n_q          <= '0;
            a_base_q     <= '0;
            b_base_q     <= '0;
            dst_base_q   <= '0;
            carry_init_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            a_base_q     <= a_base_d;
            b_base_q     <= b_base_d;
            dst_base_q   <= dst_base_d;
            carry_init_q <= carry_init_d;
        end
    end

    // LOAD fetches plane 0; each RUN cycle prefetches the next plane.
    assign w_rd_idx = (state_q == S_LOAD) ? 6'd0 : (k_q + 6'd1);
    assign w_wr_idx = (state_q == S_CARRY) ? n_q : k_q;

    assign ready_out        = (state_q == S_IDLE);
    assign done_out         = (state_q == S_DONE);
    assign rd_en_out        = !w_abort && ((state_q == S_LOAD) ||
                                           ((state_q == S_RUN) && !w_last));
    assign rd_addr_a_out    = rd_en_out ? (a_base_q + ADDR_W'(w_rd_idx)) : '0;
    assign rd_addr_b_out    = rd_en_out ? (b_base_q + ADDR_W'(w_rd_idx)) : '0;
    assign load_carry_out   = !w_abort && (state_q == S_LOAD);
    assign update_carry_out = !w_abort && (state_q == S_RUN);
    assign carry_out        = load_carry_out ? carry_init_q : '0;
    assign wr_en_out        = !w_abort && ((state_q == S_RUN) || (state_q == S_CARRY));
    assign wr_addr_out      = wr_en_out ? (dst_base_q + ADDR_W'(w_wr_idx)) : '0;
    assign wr_data_out      = wr_en_out ? sum_in : '0;

    // Zero planes in CARRY make the adder's sum equal the final carry.
    assign and_out = (state_q == S_CARRY) ? '0 : and_in;
    assign xor_out = (state_q == S_CARRY) ? '0 : xor_in;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_serial_add_seq
// Description : Self-checking bench with array/adder model and write/read
//               scoreboard for serial_add_seq.
// Revision    : 1.0
//==============================================================================
`timescale 1ns/1ps
module tb_serial_add_seq;
    localparam int LANES    = 32;
    localparam int MAX_BITS = 32;
    localparam int ADDR_W   = 8;
`ifdef SERIAL_ADD_CARRY_WB_EN
    localparam bit CWB = 1'b1;
`else
    localparam bit CWB = 1'b0;
`endif

    logic              clk, rst;
    logic              start_in, abort_in;
    logic [ADDR_W-1:0] a_base_in, b_base_in, dst_base_in;
    logic [5:0]        nbits_in;
    logic [LANES-1:0]  carry_init_in;
    logic              ready_out, done_out, rd_en_out;
    logic [ADDR_W-1:0] rd_addr_a_out, rd_addr_b_out, wr_addr_out;
    logic [LANES-1:0]  and_in, xor_in, and_out, xor_out, carry_out, sum_in, wr_data_out;
    logic              load_carry_out, update_carry_out, wr_en_out;

    serial_add_seq #(.LANES(LANES), .MAX_BITS(MAX_BITS), .ADDR_W(ADDR_W)) dut (
        .sys_clk_in(clk), .sys_reset_in(rst), .start_in(start_in), .abort_in(abort_in),
        .a_base_in(a_base_in), .b_base_in(b_base_in), .dst_base_in(dst_base_in),
        .nbits_in(nbits_in), .carry_init_in(carry_init_in), .ready_out(ready_out),
        .done_out(done_out), .rd_en_out(rd_en_out), .rd_addr_a_out(rd_addr_a_out),
        .rd_addr_b_out(rd_addr_b_out), .and_in(and_in), .xor_in(xor_in),
        .and_out(and_out), .xor_out(xor_out), .load_carry_out(load_carry_out),
        .update_carry_out(update_carry_out), .carry_out(carry_out), .sum_in(sum_in),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array + serial adder model
    logic [LANES-1:0] mem [0:255];
    logic [LANES-1:0] and_pl, xor_pl, carry_reg;
    logic             pre_we;
    logic [7:0]       pre_addr;
    logic [LANES-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (wr_en_out) mem[wr_addr_out] <= wr_data_out;
        if (rd_en_out) begin
            and_pl <= mem[rd_addr_a_out] & mem[rd_addr_b_out];
            xor_pl <= mem[rd_addr_a_out] ^ mem[rd_addr_b_out];
        end
        if (load_carry_out) carry_reg <= carry_out;
        else if (update_carry_out) carry_reg <= and_out | (xor_out & carry_reg);
    end
    assign and_in = and_pl;
    assign xor_in = xor_pl;
    assign sum_in = xor_out ^ carry_reg;

    typedef struct packed {
        logic [7:0]       addr;
        logic [LANES-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [7:0]       a_base;
        logic [7:0]       b_base;
        logic [7:0]       dst;
        logic [5:0]       nbits;
        logic [31:0]      a0;
        logic [31:0]      b0;
        logic [31:0]      astep;
        logic [31:0]      bstep;
        logic [LANES-1:0] cinit;
        logic             abort_start;
    } op_t;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    wr_t         mon_wexp;
    logic [15:0] mon_rexp;
    int          checks, errors, wr_seen;
    bit          mon_en;
    op_t         ops[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every DUT read/write is popped against the expected queues
    always @(negedge clk) begin
        #2;
        if (mon_en && wr_en_out) begin
            wr_seen++;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h", wr_addr_out, wr_data_out);
            end else begin
                mon_wexp = wr_q.pop_front();
                if ({wr_addr_out, wr_data_out} !== mon_wexp) begin
                    errors++;
                    $display("FAIL write actual=%0h/%0h expected=%0h/%0h",
                             wr_addr_out, wr_data_out, mon_wexp.addr, mon_wexp.data);
                end
            end
        end
        if (mon_en && rd_en_out) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read a=%0h b=%0h", rd_addr_a_out, rd_addr_b_out);
            end else begin
                mon_rexp = rd_q.pop_front();
                if ({rd_addr_a_out, rd_addr_b_out} !== mon_rexp) begin
                    errors++;
                    $display("FAIL read actual=%0h/%0h expected=%0h", rd_addr_a_out,
                             rd_addr_b_out, mon_rexp);
                end
            end
        end
    end

    // which: 0 = A plane, 1 = B plane, 2 = sum plane (bit k of A+B+cin per lane)
    function automatic logic [LANES-1:0] plane(input op_t op, input int n, input int k,
                                               input int which);
        logic [63:0]      mask, av, bv, s;
        logic [LANES-1:0] p;
        mask = (n == 0) ? 64'd0 : ((64'd1 << n) - 64'd1);
        for (int l = 0; l < LANES; l++) begin
            av = (64'(op.a0) + 64'(l) * 64'(op.astep)) & mask;
            bv = (64'(op.b0) + 64'(l) * 64'(op.bstep)) & mask;
            s  = av + bv + 64'(op.cinit[l]);
            p[l] = (which == 0) ? av[k] : ((which == 1) ? bv[k] : s[k]);
        end
        return p;
    endfunction

    function automatic int eff_n(input op_t op);
        return (int'(op.nbits) > MAX_BITS) ? MAX_BITS : int'(op.nbits);
    endfunction

    task automatic preload(input op_t op, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 8'(op.a_base + k); pre_data = plane(op, n, k, 0);
            @(negedge clk);
            pre_addr = 8'(op.b_base + k); pre_data = plane(op, n, k, 1);
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive_start(input op_t op);
        @(negedge clk);
        start_in = 1'b1; abort_in = op.abort_start;
        a_base_in = op.a_base; b_base_in = op.b_base; dst_base_in = op.dst;
        nbits_in = op.nbits; carry_init_in = op.cinit;
        #1 chk("ready_before_start", 64'(ready_out), 64'd1);
        @(negedge clk);
        start_in = 1'b0; abort_in = 1'b0;
        // Scramble inputs so only latched parameters can produce correct results
        a_base_in = ~op.a_base; b_base_in = ~op.b_base; dst_base_in = ~op.dst;
        nbits_in = 6'd1; carry_init_in = ~op.cinit;
    endtask

    task automatic run_op(input op_t op);
        int n, expd, dcnt, dcyc, w0;
        n = eff_n(op);
        preload(op, n);
        for (int k = 0; k < n; k++) begin
            wr_q.push_back('{addr: 8'(op.dst + k), data: plane(op, n, k, 2)});
            rd_q.push_back({8'(op.a_base + k), 8'(op.b_base + k)});
        end
        if (CWB && n > 0) wr_q.push_back('{addr: 8'(op.dst + n), data: plane(op, n, n, 2)});
        w0 = wr_seen;
        drive_start(op);
        expd = (n == 0) ? 1 : n + 2 + int'(CWB);
        dcyc = -1; dcnt = 0;
        for (int c = 1; c <= n + 6; c++) begin
            #1;
            if (done_out) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
            if (c == 1) chk("ready_low_cycle1", 64'(ready_out), 64'd0);
            if (c == expd + 1) chk("ready_after_done", 64'(ready_out), 64'd1);
            @(negedge clk);
        end
        chk("done_cycle", 64'(dcyc), 64'(expd));
        chk("done_pulses", 64'(dcnt), 64'd1);
        chk("write_count", 64'(wr_seen - w0), 64'(n + ((CWB && n > 0) ? 1 : 0)));
        chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; wr_seen = 0; mon_en = 1'b1;
        rst = 1'b1; start_in = 1'b0; abort_in = 1'b0; pre_we = 1'b0;
        pre_addr = '0; pre_data = '0; a_base_in = '0; b_base_in = '0;
        dst_base_in = '0; nbits_in = '0; carry_init_in = '0;

        //               a_base b_base dst   n   a0      b0      astep   bstep  cinit  abort
        ops[0] = '{8'h00, 8'h20, 8'h40, 6'd4,  32'd5,  32'd3,  32'd1, 32'd2, 32'h0, 1'b0};
        ops[1] = '{8'h10, 8'h30, 8'h50, 6'd4,  32'hF,  32'h1,  32'd0, 32'd0, 32'h0, 1'b1};
        ops[2] = '{8'h60, 8'h70, 8'h88, 6'd4,  32'd9,  32'hB,  32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0};
        ops[3] = '{8'h90, 8'hA0, 8'hB0, 6'd0,  32'd7,  32'd7,  32'd1, 32'd1, 32'h1234_5678, 1'b0};
        ops[4] = '{8'h00, 8'h40, 8'h80, 6'd40, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0101_0101,
                   32'd7, 32'hA5A5_A5A5, 1'b0};
        ops[5] = '{8'hFE, 8'h10, 8'hFF, 6'd3,  32'd5,  32'd6,  32'd3, 32'd1, 32'h0F0F_0F0F, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(ready_out), 64'd1);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_rd_en", 64'(rd_en_out), 64'd0);
        chk("rst_wr_en", 64'(wr_en_out), 64'd0);
        chk("rst_ctrl", {62'd0, load_carry_out, update_carry_out}, 64'd0);
        chk("rst_carry_out", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_op(ops[i]);

        // Abort at RUN k=1: only the k=0 write and the first two reads happen
        preload(ops[0], 4);
        wr_q.push_back('{addr: 8'h40, data: plane(ops[0], 4, 0, 2)});
        rd_q.push_back(16'h0020);
        rd_q.push_back(16'h0121);
        drive_start(ops[0]);        // cycle 1 (LOAD)
        @(negedge clk);             // cycle 2 (RUN k=0)
        @(negedge clk);             // cycle 3 (RUN k=1)
        abort_in = 1'b1;
        #1;
        chk("abort_wr_en", 64'(wr_en_out), 64'd0);
        chk("abort_rd_en", 64'(rd_en_out), 64'd0);
        chk("abort_update", 64'(update_carry_out), 64'd0);
        @(negedge clk);
        abort_in = 1'b0;
        #1;
        chk("abort_ready_next", 64'(ready_out), 64'd1);
        for (int c = 0; c < 5; c++) begin
            chk("abort_no_done", 64'(done_out), 64'd0);
            @(negedge clk);
            #1;
        end
        chk("abort_wr_queue_empty", 64'(wr_q.size()), 64'd0);
        chk("abort_rd_queue_empty", 64'(rd_q.size()), 64'd0);

        // Asynchronous reset mid-RUN
        mon_en = 1'b0;
        drive_start(ops[4]);
        repeat (4) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_rd_en", 64'(rd_en_out), 64'd0);
        chk("arst_wr_en", 64'(wr_en_out), 64'd0);
        chk("arst_addrs", {40'd0, rd_addr_a_out, rd_addr_b_out, wr_addr_out}, 64'd0);
        chk("arst_ctrl", {61'd0, load_carry_out, update_carry_out, done_out}, 64'd0);
        chk("arst_ready", 64'(ready_out), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        rd_q.delete();
        mon_en = 1'b1;
        run_op(ops[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
